instr_mem_responder: RTL

Instruction-memory responder at the far end of the fetch interface driven by the program counter. It accepts word-aligned fetch addresses over a valid/ready request channel. It returns the stored instruction words in order over a valid/ready response channel after a fixed pipeline latency. Branch/jump redirects drop every outstanding fetch through a flush input. A word-wide load port fills the memory before or between runs.

---
 rtl/instr_mem_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: credit-limited fetch pipeline feeding an
// in-order response FIFO, with a flush for redirects and a word load port.
module instr_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_addr,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [31:0]                    rsp_instr,
    output logic [31:0]                    rsp_addr,
    output logic                           rsp_err,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
    input  logic [31:0]                    load_data
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    // Instruction storage; deliberately not reset so contents survive reset
    logic [31:0]   r_mem [DEPTH_WORDS];

    // Fetch pipeline stages
    logic          r_pv  [LATENCY];
    logic [31:0]   r_pi  [LATENCY];
    logic [31:0]   r_pa  [LATENCY];
    logic          r_pe  [LATENCY];

    // Response FIFO storage and pointers (extra MSB distinguishes full/empty)
    logic [31:0]   r_fi  [FIFO_DEPTH];
    logic [31:0]   r_fa  [FIFO_DEPTH];
    logic          r_fe  [FIFO_DEPTH];
    logic [PW:0]   r_wr;
    logic [PW:0]   r_rd;

    // Outstanding fetches: pipeline entries plus queued responses
    logic [CW-1:0] r_out;

    logic [AW-1:0] w_idx;
    logic          w_err;
    logic          w_acc;
    logic          w_pop;
    logic          w_push;

    assign w_idx     = req_addr[AW+1:2];
    assign w_err     = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
    assign req_ready = (r_out < CW'(FIFO_DEPTH)) && !flush;
    assign w_acc     = req_valid && req_ready;
    assign rsp_valid = (r_wr != r_rd);
    assign w_pop     = rsp_valid && rsp_ready;
    assign w_push    = r_pv[LATENCY-1];
    assign rsp_instr = r_fi[r_rd[PW-1:0]];
    assign rsp_addr  = r_fa[r_rd[PW-1:0]];
    assign rsp_err   = r_fe[r_rd[PW-1:0]];

    // Load port writes memory independently of fetch, flush and reset
    always_ff @(posedge clk) begin
        if (load_en) begin
            r_mem[load_addr] <= load_data;
        end
    end

    // Fetch pipeline: read memory at acceptance, then shift toward the FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                r_pv[i] <= 1'b0;
                r_pi[i] <= '0;
                r_pa[i] <= '0;
                r_pe[i] <= 1'b0;
            end
        end else if (flush) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                r_pv[i] <= 1'b0;
            end
        end else begin
            r_pv[0] <= w_acc;
            r_pi[0] <= w_err ? 32'h0 : r_mem[w_idx];
            r_pa[0] <= req_addr;
            r_pe[0] <= w_err;
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pi[i] <= r_pi[i-1];
                r_pa[i] <= r_pa[i-1];
                r_pe[i] <= r_pe[i-1];
            end
        end
    end

    // Response FIFO: write from last pipeline stage, read on handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr <= '0;
            r_rd <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_fi[i] <= '0;
                r_fa[i] <= '0;
                r_fe[i] <= 1'b0;
            end
        end else if (flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) begin
                r_fi[r_wr[PW-1:0]] <= r_pi[LATENCY-1];
                r_fa[r_wr[PW-1:0]] <= r_pa[LATENCY-1];
                r_fe[r_wr[PW-1:0]] <= r_pe[LATENCY-1];
                r_wr               <= r_wr + (PW+1)'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + (PW+1)'(1);
            end
        end
    end

    // Credit counter: accept adds, response handshake removes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out <= '0;
        end else if (flush) begin
            r_out <= '0;
        end else if (w_acc && !w_pop) begin
            r_out <= r_out + CW'(1);
        end else if (!w_acc && w_pop) begin
            r_out <= r_out - CW'(1);
        end
    end

endmodule
